// File: rtl/midi_btn_ctrl.sv
// N-button MIDI note controller: per-button sync/debounce lanes feed a lowest-index
// arbiter and a 31250-baud 8N1 transmitter emitting Note On / Note Off messages.

module midi_btn_ctrl_db #(
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic db
);
  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the accepted
  // state; any return to agreement restarts the stability window.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CNT - 1)) db_d = sync2_q;
      else                                cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db = db_q;
endmodule

module midi_btn_ctrl #(
  parameter int NUM_BTN        = 4,
  parameter int BAUD_CNT_HALF  = 800,
  parameter int DEBOUNCE_CNT   = 50000,
  parameter int BASE_NOTE      = 60,
  parameter int RUNNING_STATUS = 0,
  parameter int NOTE_OFF_VEL0  = 0,
  parameter int LED_STRETCH    = 2500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [3:0]         midi_ch,
  input  logic [6:0]         velocity,
  output logic               midi_tx,
  output logic               busy,
  output logic               led_act,
  output logic               led_held
);
  localparam int BIT_CLKS = 2 * BAUD_CNT_HALF;
  localparam int BW       = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam int IW       = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int LW       = (LED_STRETCH > 1) ? $clog2(LED_STRETCH + 1) : 1;
  localparam logic [6:0] BASE7 = 7'(BASE_NOTE % 128);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  logic [NUM_BTN-1:0] db, pending;
  logic [NUM_BTN-1:0] sent_q, sent_d;
  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d, sel_idx;
  logic [BW-1:0]      cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         nbytes_q, nbytes_d;
  logic [23:0]        msg_q, msg_d;
  logic [7:0]         last_status_q, last_status_d;
  logic [LW-1:0]      led_cnt_q, led_cnt_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               led_held_q, led_held_d;
  logic               st;
  logic [6:0]         note, vel;
  logic [7:0]         status, b3;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
    midi_btn_ctrl_db #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db (
      .clk (clk),
      .rst (rst),
      .din (btn[gi]),
      .db  (db[gi])
    );
  end

  assign pending = db ^ sent_q;

  // Descending scan so the lowest pending index is the last one written.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--)
      if (pending[i]) sel_idx = IW'(i);
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    nbytes_d      = nbytes_q;
    msg_d         = msg_q;
    sent_d        = sent_q;
    last_status_d = last_status_q;
    led_cnt_d     = (led_cnt_q != '0) ? led_cnt_q - 1'b1 : '0;
    st            = 1'b0;
    note          = '0;
    vel           = '0;
    status        = '0;
    b3            = '0;
    case (state_q)
      S_IDLE: if (|pending) begin
        state_d = S_LOAD;
        idx_d   = sel_idx;
      end
      S_LOAD: begin
        st          = db[idx_q];
        sent_d[idx_q] = st;
        note        = BASE7 + 7'(idx_q);
        vel         = (velocity == 7'd0) ? 7'd1 : velocity;
        if (st)                 begin status = {4'h9, midi_ch}; b3 = {1'b0, vel}; end
        else if (NOTE_OFF_VEL0 != 0) begin status = {4'h9, midi_ch}; b3 = 8'h00;  end
        else                    begin status = {4'h8, midi_ch}; b3 = 8'h40;        end
        // Byte 0 sits in msg[7:0]; the whole word shifts right one bit per data bit.
        if (RUNNING_STATUS != 0 && status == last_status_q) begin
          msg_d    = {8'h00, b3, 1'b0, note};
          nbytes_d = 2'd2;
        end else begin
          msg_d    = {b3, 1'b0, note, status};
          nbytes_d = 2'd3;
        end
        last_status_d = status;
        led_cnt_d     = LW'(LED_STRETCH);
        cnt_d         = BW'(BIT_CLKS - 1);
        state_d       = S_START;
      end
      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = BW'(BIT_CLKS - 1);
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BW'(BIT_CLKS - 1);
          msg_d = msg_q >> 1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (nbytes_q > 2'd1) begin
            nbytes_d = nbytes_q - 2'd1;
            cnt_d    = BW'(BIT_CLKS - 1);
            state_d  = S_START;
          end else state_d = S_IDLE;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Line level and busy are decoded from the next state so they register cleanly.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = msg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d     = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    led_held_d = |db;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      bit_q         <= '0;
      nbytes_q      <= '0;
      msg_q         <= '0;
      sent_q        <= '0;
      last_status_q <= '0;
      led_cnt_q     <= '0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      led_held_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      nbytes_q      <= nbytes_d;
      msg_q         <= msg_d;
      sent_q        <= sent_d;
      last_status_q <= last_status_d;
      led_cnt_q     <= led_cnt_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      led_held_q    <= led_held_d;
    end
  end

  assign midi_tx  = tx_q;
  assign busy     = busy_q;
  assign led_act  = (led_cnt_q != '0);
  assign led_held = led_held_q;
endmodule
